// File: rtl/surv_mem_banked.sv
// Banked survivor memory. Each of NBANKS banks holds DEPTH rows of DATA_W
// bits and is accessed independently. After reset, a sweep zeroes every row of
// every bank, one row per cycle, before user accesses are accepted. Every access
// returns a result one cycle later, or two cycles later when OUT_REG=1.
module surv_mem_banked #(
    parameter int NBANKS  = 6,
    parameter int DEPTH   = 21,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64,
    parameter int OUT_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NBANKS-1:0]        cs,
    input  logic [NBANKS-1:0]        we,
    input  logic [NBANKS*ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [NBANKS*DATA_W-1:0] rdata,
    output logic [NBANKS-1:0]        rvalid,
    output logic [NBANKS-1:0]        addr_err,
    output logic                     busy
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              run;

    // Register the sweep state and the row counter of the clear sweep.
    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // pre-edge values, regardless of the order in which blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Step through rows 0..DEPTH-1 in CLEAR, then stay in RUN until reset.
    // NOTE: defaults come first so that every path assigns each signal and no
    // latch is inferred.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == LAST_ROW) begin
                    state_nxt   = ST_RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy = (state == ST_CLEAR);
    assign run  = (state == ST_RUN);

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] a;
        logic              oob;
        logic              acc;
        logic [DATA_W-1:0] s1_data;
        logic              s1_valid;
        logic              s1_err;

        assign a   = addr[b*ADDR_W +: ADDR_W];
        assign oob = (32'(a) >= DEPTH);
        assign acc = run & cs[b];

        // Storage: the clear sweep writes zeros; in RUN, in-range user writes land.
        // NOTE: the array has no reset branch, so it maps onto RAM; zeroing is
        // done only by the sweep, and reset leaves the contents untouched.
        always_ff @(posedge clk) begin
            if (!reset) begin
                if (!run) begin
                    mem[clr_cnt] <= '0;
                end else if (cs[b] && we[b] && !oob) begin
                    mem[a] <= wdata;
                end
            end
        end

        // First result stage: write-through, read-before-write, zero on out-of-range.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_data  <= '0;
                s1_valid <= 1'b0;
                s1_err   <= 1'b0;
            end else begin
                s1_valid <= acc;
                s1_err   <= acc & oob;
                if (acc) begin
                    if (oob) begin
                        s1_data <= '0;
                    end else if (we[b]) begin
                        s1_data <= wdata;
                    end else begin
                        s1_data <= mem[a];
                    end
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;
            logic              s2_err;

            // Optional output stage; data holds when no new result arrives.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rdata[b*DATA_W +: DATA_W] = s2_data;
            assign rvalid[b]                 = s2_valid;
            assign addr_err[b]               = s2_err;
        end else begin : g_nreg
            assign rdata[b*DATA_W +: DATA_W] = s1_data;
            assign rvalid[b]                 = s1_valid;
            assign addr_err[b]               = s1_err;
        end
    end

endmodule

// File: doc/surv_mem_banked.md
SURV_MEM_BANKED -- requirements
Module: surv_mem_banked

Interface
REQ-001 SHALL have parameter NBANKS, 6, number of independent survivor-memory banks.
REQ-002 SHALL have parameter DEPTH, 21, rows per bank.
REQ-003 SHALL have parameter ADDR_W, 5, address width per bank; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter DATA_W, 64, row width in bits.
REQ-005 SHALL have parameter OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port cs  input  NBANKS  per-bank chip select, active high.
REQ-009 SHALL have port we  input  NBANKS  per-bank write enable, qualified by cs.
REQ-010 SHALL have port addr  input  NBANKS*ADDR_W  per-bank address, bank b at bits [b*ADDR_W +: ADDR_W].
REQ-011 SHALL have port wdata  input  DATA_W  write data shared by all banks.
REQ-012 SHALL have port rdata  output  NBANKS*DATA_W  per-bank read data, bank b at [b*DATA_W +: DATA_W].
REQ-013 SHALL have port rvalid  output  NBANKS  per-bank pulse, high in the cycle rdata of that bank carries a new access result.
REQ-014 SHALL have port addr_err  output  NBANKS  per-bank one-cycle pulse flagging an access with addr >= DEPTH.
REQ-015 SHALL have port busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and RUN; reset forces CLEAR with clear counter = 0.
REQ-017 In CLEAR, each cycle SHALL write all-zero to row clear counter in every bank, then increment; at counter = DEPTH-1 the row is written and the FSM moves to RUN next cycle (CLEAR lasts exactly DEPTH cycles).
REQ-018 busy SHALL be 1 in CLEAR and 0 in RUN.
REQ-019 In CLEAR, cs/we/addr SHALL be ignored: no user write, rvalid = 0, addr_err = 0.
REQ-020 In RUN, banks SHALL operate independently; bank b is accessed only when cs[b] = 1.
REQ-021 Write (cs=1, we=1, addr<DEPTH): row addr SHALL be updated with wdata and the access result SHALL be wdata (write-through).
REQ-022 Read (cs=1, we=0, addr<DEPTH): access result SHALL be the row contents before any same-cycle update.
REQ-023 Out-of-range (cs=1, addr>=DEPTH): memory SHALL be unchanged, access result SHALL be all-zero, addr_err[b] pulses with the result.
REQ-024 cs[b]=0 SHALL leave rdata of bank b holding its last value (never high-impedance) and rvalid[b]=0.
REQ-025 With OUT_REG=0, rdata/rvalid/addr_err SHALL appear the cycle after the access edge; with OUT_REG=1, one cycle later, back-to-back accesses fully pipelined (one per cycle per bank).
REQ-026 Accesses to different banks in the same cycle SHALL never interact; the same row read and written in consecutive cycles SHALL return the newly written data.

Reset
REQ-027 While reset=1 at a clock edge: rdata = 0, rvalid = 0, addr_err = 0, busy = 1 on the following cycle, all pipeline stages cleared.
REQ-028 Reset asserted mid-CLEAR or mid-RUN SHALL abort in-flight accesses (no rvalid produced for them) and restart the clear sweep from row 0.
REQ-029 Memory contents SHALL only be zeroed by the clear sweep, not by reset itself.

Verification
REQ-030 Reset 2 cycles, release -> busy high exactly 21 cycles, then 0; read of any row in any bank returns 0 with rvalid=1.
REQ-031 OUT_REG=0: write bank2 addr 7 data 64'hDEAD_BEEF_0123_4567 -> rdata bank2 = that value next cycle; read addr 7 next cycle -> same value, rvalid[2]=1 after 1 cycle.
REQ-032 Bank0 addr 25 read and bank3 addr 21 write 64'hFF.. -> addr_err = 6'b001001, rdata of both = 0, subsequent read of bank3 rows 0..20 unchanged.
REQ-033 OUT_REG=1: 4 consecutive reads of rows 0..3 in bank5 -> rvalid[5] high cycles 2..5 with matching data; cs low afterwards -> rdata holds row 3 value.
REQ-034 Assert reset at clear counter = 10 -> busy stays high a full 21 cycles after release; reset during a pending OUT_REG=1 read -> no rvalid pulse.
REQ-035 All 6 banks written with distinct values in one cycle, then all read in one cycle -> each bank returns its own value, no cross-bank corruption.
